// File: rtl/ws_video_timing.sv
// rtl/ws_video_timing.sv - CEA-861 720x480p raster timing with a centred integer-scaled source window
//
// Purpose:
//   Free-running raster counters for the TMDS output stage, plus the
//   coordinate stream for the scaler read side and line-prefetch requests
//   for the line-buffer fill side. Every output is registered and describes
//   the (h, v) counter state of the previous clock.
//
// Ports:
//   clk          pixel clock (27 MHz)
//   rst          asynchronous reset, active-high
//   hsync        horizontal sync, SYNC_POL while active
//   vsync        vertical sync, SYNC_POL while active (changes at h = 0 only)
//   de           data enable for the active raster
//   in_window    pixel lies inside the scaled source window
//   src_x        source column, valid while in_window
//   src_y        source line, valid while in_window
//   frame_start  one-cycle pulse at h = 0, v = 0
//   line_req     one-cycle pulse at start of hblank asking for line_req_y
//   line_req_y   source line to prefetch, held until the next line_req

module ws_video_timing #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter bit SYNC_POL = 1'b0,
    parameter int SCALE    = 3,
    parameter int SRC_W    = 224,
    parameter int SRC_H    = 144
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       in_window,
    output logic [7:0] src_x,
    output logic [7:0] src_y,
    output logic       frame_start,
    output logic       line_req,
    output logic [7:0] line_req_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    // Window placement is fixed at elaboration; no arithmetic reaches silicon.
    localparam int WX0 = (H_ACTIVE - SRC_W * SCALE) / 2;
    localparam int WX1 = WX0 + SRC_W * SCALE;
    localparam int WY0 = (V_ACTIVE - SRC_H * SCALE) / 2;
    localparam int WY1 = WY0 + SRC_H * SCALE;

    // Line whose hblank carries the request for the first window line.
    localparam int V_PRE = (WY0 == 0) ? V_TOTAL - 1 : WY0 - 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_WX0  = HW'(WX0);
    localparam logic [HW-1:0] H_WX1  = HW'(WX1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_WY0  = VW'(WY0);
    localparam logic [VW-1:0] V_WY1  = VW'(WY1);
    localparam logic [VW-1:0] V_WLM1 = VW'(WY1 - 1);
    localparam logic [VW-1:0] V_PREL = VW'(V_PRE);

    localparam logic [PW-1:0] PH_LAST   = PW'(SCALE - 1);
    localparam logic [7:0]    SRC_X_MAX = 8'(SRC_W - 1);
    localparam logic [7:0]    SRC_Y_MAX = 8'(SRC_H - 1);

    generate
        if (SRC_W * SCALE > H_ACTIVE || SRC_H * SCALE > V_ACTIVE ||
            SRC_W > 256 || SRC_H > 256 || SCALE < 1) begin : g_bad_geometry
            $error("ws_video_timing: scaled source window does not fit the raster");
        end
    endgenerate

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [PW-1:0] x_phase;
    logic [PW-1:0] y_phase;
    logic          h_in_win;
    logic          v_in_win;

    always_comb begin
        h_in_win = (h_cnt >= H_WX0) && (h_cnt < H_WX1);
        v_in_win = (v_cnt >= V_WY0) && (v_cnt < V_WY1);
    end

    // Raster counters: h and v wrap together on the last pixel of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Sync, enable and frame marker decode the current counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            in_window   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_cnt >= H_HS0 && h_cnt < H_HS1) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_cnt >= V_VS0 && v_cnt < V_VS1) ? SYNC_POL : ~SYNC_POL;
            de          <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            in_window   <= h_in_win && v_in_win;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Horizontal scaling: src_x/x_phase hold the values of the previous
    // pixel, so each edge steps them to the pixel now on the counters.
    // The clear at the window edge re-aligns every line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_x   <= '0;
            x_phase <= '0;
        end else if (h_cnt == H_WX0) begin
            src_x   <= '0;
            x_phase <= '0;
        end else if (h_in_win) begin
            if (x_phase == PH_LAST) begin
                x_phase <= '0;
                if (src_x != SRC_X_MAX) begin
                    src_x <= src_x + 8'd1;
                end
            end else begin
                x_phase <= x_phase + 1'b1;
            end
        end
    end

    // Vertical scaling steps once per line, on the first pixel of the line,
    // so src_y is stable for the whole of every window line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_y   <= '0;
            y_phase <= '0;
        end else if (h_cnt == '0) begin
            if (v_cnt == V_WY0) begin
                src_y   <= '0;
                y_phase <= '0;
            end else if (v_in_win) begin
                if (y_phase == PH_LAST) begin
                    y_phase <= '0;
                    if (src_y != SRC_Y_MAX) begin
                        src_y <= src_y + 8'd1;
                    end
                end else begin
                    y_phase <= y_phase + 1'b1;
                end
            end
        end
    end

    // Prefetch: at start of hblank on line v, request line v+1 if it opens a
    // new source line. Inside the window that is exactly when line v is the
    // last repeat of its source line (phase at SCALE-1), excluding the final
    // window line. src_y/y_phase already describe line v at this point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_req   <= 1'b0;
            line_req_y <= '0;
        end else begin
            line_req <= 1'b0;
            if (h_cnt == H_ACT) begin
                if (v_cnt == V_PREL) begin
                    line_req   <= 1'b1;
                    line_req_y <= '0;
                end else if (v_cnt >= V_WY0 && v_cnt < V_WLM1 && y_phase == PH_LAST) begin
                    line_req   <= 1'b1;
                    line_req_y <= src_y + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/ws_video_timing.md
Name: ws_video_timing

Overview:
- Generates CEA-861 720x480p59.94 raster timing (VIC 2, 858x525 total, 27 MHz pixel clock) for the HDMI/TMDS output stage.
- Also generates the centred integer-scaled WonderSwan window: 224x144 source at 3x gives 672x432.
- Drives pixel coordinates into the scaler/line-buffer read side, and line-prefetch requests to the line-buffer fill side.
- Sits between the frame/line buffer and the TMDS encoder.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 62, hsync width
- H_BP, 60, horizontal back porch (H_TOTAL = 858)
- V_ACTIVE, 480, active lines
- V_FP, 9, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 30, vertical back porch (V_TOTAL = 525)
- SYNC_POL, 0, active sync level (0 = negative, as VIC 2)
- SCALE, 3, integer upscale factor
- SRC_W, 224, source width in pixels
- SRC_H, 144, source height in lines

Ports:
- clk  in  1  pixel clock, 27 MHz
- rst  in  1  asynchronous reset, active-high
- hsync  out  1  horizontal sync, level SYNC_POL when active
- vsync  out  1  vertical sync, level SYNC_POL when active
- de  out  1  data enable, active raster
- in_window  out  1  pixel lies in scaled source window
- src_x  out  8  source column 0..SRC_W-1, valid when in_window
- src_y  out  8  source line 0..SRC_H-1, valid when in_window
- frame_start  out  1  one-cycle pulse at the first pixel of a frame
- line_req  out  1  one-cycle pulse requesting prefetch of source line line_req_y
- line_req_y  out  8  source line to prefetch, held until next line_req

Behaviour:
- Reset (async assert; release takes effect on the next clk edge):
  - h_cnt = 0, v_cnt = 0, x/y phase = 0.
  - hsync = vsync = ~SYNC_POL.
  - de, in_window, frame_start, line_req = 0.
  - src_x, src_y, line_req_y = 0.
- Reset asserted mid-frame returns everything to these values immediately. The first raster after release starts at h = 0, v = 0.
- Counters:
  - h_cnt counts 0..857 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..524 and wraps to 0.
  - Frame = 450450 clocks.
- Output timing: all outputs are registered and share exactly one clock of latency from the counter state they decode. The output in cycle n+1 describes (h, v) of cycle n.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync is active for h in [736, 798).
- vsync is active for v in [489, 495). It changes only at the h = 0 boundary.
- Window geometry:
  - WX0 = (H_ACTIVE - SRC_W*SCALE)/2 = 24; WY0 = (V_ACTIVE - SRC_H*SCALE)/2 = 24.
  - in_window = h in [24, 696) && v in [24, 456).
  - Offsets are computed at elaboration; synthesis fails if SRC_W*SCALE > H_ACTIVE or SRC_H*SCALE > V_ACTIVE.
- src_x:
  - x-phase counter 0..SCALE-1 runs only inside the window. src_x increments when the phase wraps.
  - Both clear at h = WX0 on every line.
  - src_x stays at SRC_W-1 after the window and never exceeds it.
- src_y:
  - y-phase advances once per window line at the h wrap; src_y increments when the phase wraps.
  - Both clear at v = WY0.
  - src_y holds at SRC_H-1 below the window.
- Division: no divider or multiplier is used. Scaling is done by the phase counters only.
- line_req:
  - One-cycle pulse at h = H_ACTIVE (start of hblank) on line v, when line v+1 is a window line with y-phase 0.
  - line_req_y = source line displayed on v+1.
  - First request fires on v = 23 with line_req_y = 0. Last fires on v = 452 with line_req_y = 143.
  - Exactly SRC_H requests per frame.
- frame_start is high for one cycle, in the output cycle that corresponds to h = 0, v = 0.
- Wrap-around: at the h = 857/v = 524 to 0/0 transition, all counters and phases wrap in the same edge. No glitch on any output.

Test Plan:
- Reset: hold rst across several clocks, then release → all outputs at reset values; first frame_start exactly 1 clock after the first edge post-release; next frame_start 450450 clocks later.
- H timing: measure one line → de high 720 clocks; hsync low for 62 clocks starting 736 clocks after de rise; line period 858.
- V timing: measure one frame → 480 de lines; vsync low for 6 lines starting at line 489; vsync edges coincide with h = 0 output cycles.
- Window X: on line v = 24 → in_window rises at h = 24 with src_x = 0; src_x = 1 at h = 27; src_x = 223 at h = 693..695; in_window falls at h = 696.
- Window Y and line_req: count per frame → 144 line_req pulses; first at (h = 720, v = 23) with line_req_y = 0; second at v = 26 with line_req_y = 1; src_y = 143 on lines 453..455; no in_window on v = 456.
- Async reset mid-window: assert rst at (h = 300, v = 200) → outputs reset within the same cycle without waiting for clk; after release, timing restarts from h = 0, v = 0 with no partial line emitted.
